// File: rtl/textbuffer_ctrl_pkg.sv
// Shared definitions for the textbuffer bus controller: command encodings,
// engine state encodings and the plane-select bit helper.
package textbuffer_ctrl_pkg;

  localparam logic CMD_CLEAR  = 1'b0;
  localparam logic CMD_SCROLL = 1'b1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COPY_RD = 3'd1;
  localparam logic [2:0] ST_COPY_WR = 3'd2;
  localparam logic [2:0] ST_FILL    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // The plane select is the top address bit; the cell index sits below it.
  function automatic int plane_bit(input int aw);
    return aw - 1;
  endfunction

endpackage

// File: rtl/textbuffer_ctrl.sv
// Arbitrates the textbuffer port between the CPU and a clear/scroll engine.
// Handshake: cpu_cs requests, cpu_ready grants; the access happens on the edge where both are high, and the CPU holds cs/addr/data until then.
module textbuffer_ctrl
  import textbuffer_ctrl_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int HEIGHT = 15,
  parameter int AW     = $clog2(WIDTH * HEIGHT) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_cs,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_di,
  output logic          cpu_ready,
  output logic [7:0]    cpu_dout,
  input  logic          cmd_start,
  input  logic          cmd,
  input  logic [7:0]    fill_char,
  input  logic [7:0]    fill_attr,
  output logic          busy,
  output logic          done,
  output logic          tb_cs,
  output logic          tb_rw,
  output logic [AW-1:0] tb_addr,
  output logic [7:0]    tb_di,
  input  logic [7:0]    tb_dout,
  output logic [2:0]    dbg_state
);

  localparam int CW = AW - 1;
  localparam int PB = plane_bit(AW);
  localparam logic [CW-1:0] LAST_CELL  = CW'(WIDTH * HEIGHT - 1);
  localparam logic [CW-1:0] LAST_COPY  = CW'(WIDTH * (HEIGHT - 1) - 1);
  localparam logic [CW-1:0] LAST_ROW0  = CW'(WIDTH * (HEIGHT - 1));
  localparam logic [CW-1:0] ROW_STRIDE = CW'(WIDTH);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_plane;
  logic          r_scroll;
  logic [7:0]    r_fill_char;
  logic [7:0]    r_fill_attr;
  logic          r_rd_pend;
  logic [7:0]    r_cpu_dout;

  logic          w_idle;
  logic [CW-1:0] w_cell;
  logic [AW-1:0] w_eng_addr;

  assign w_idle    = (r_state == ST_IDLE);
  assign cpu_ready = w_idle && cpu_cs;
  assign cpu_dout  = r_cpu_dout;
  assign busy      = (r_state == ST_COPY_RD) || (r_state == ST_COPY_WR) || (r_state == ST_FILL);
  assign done      = (r_state == ST_DONE);
  assign dbg_state = r_state;

  // Copy reads fetch one row below the destination cell.
  always_comb begin
    w_cell = (r_state == ST_COPY_RD) ? (r_cnt + ROW_STRIDE) : r_cnt;
    w_eng_addr = '0;
    w_eng_addr[CW-1:0] = w_cell;
    w_eng_addr[PB] = r_plane;
  end

  always_comb begin
    tb_cs   = 1'b0;
    tb_rw   = 1'b0;
    tb_addr = '0;
    tb_di   = '0;
    case (r_state)
      ST_IDLE: begin
        tb_cs   = cpu_cs;
        tb_rw   = cpu_rw;
        tb_addr = cpu_addr;
        tb_di   = cpu_di;
      end
      ST_COPY_RD: begin
        tb_cs   = 1'b1;
        tb_addr = w_eng_addr;
      end
      ST_COPY_WR: begin
        tb_cs   = 1'b1;
        tb_rw   = 1'b1;
        tb_addr = w_eng_addr;
        tb_di   = tb_dout;
      end
      ST_FILL: begin
        tb_cs   = 1'b1;
        tb_rw   = 1'b1;
        tb_addr = w_eng_addr;
        tb_di   = r_plane ? r_fill_attr : r_fill_char;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_plane     <= 1'b0;
      r_scroll    <= 1'b0;
      r_fill_char <= '0;
      r_fill_attr <= '0;
      r_rd_pend   <= 1'b0;
      r_cpu_dout  <= '0;
    end else begin
      // Only CPU reads set the pending flag, so engine reads never reach cpu_dout.
      r_rd_pend <= w_idle && cpu_cs && !cpu_rw;
      if (r_rd_pend) r_cpu_dout <= tb_dout;

      case (r_state)
        ST_IDLE: begin
          if (cmd_start) begin
            r_scroll    <= (cmd == CMD_SCROLL);
            r_fill_char <= fill_char;
            r_fill_attr <= fill_attr;
            r_cnt       <= '0;
            r_plane     <= 1'b0;
            r_state     <= (cmd == CMD_CLEAR) ? ST_FILL : ST_COPY_RD;
          end
        end
        ST_COPY_RD: r_state <= ST_COPY_WR;
        ST_COPY_WR: begin
          if (r_cnt == LAST_COPY) begin
            if (!r_plane) begin
              r_plane <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_COPY_RD;
            end else begin
              r_plane <= 1'b0;
              r_cnt   <= LAST_ROW0;
              r_state <= ST_FILL;
            end
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= ST_COPY_RD;
          end
        end
        ST_FILL: begin
          if (r_cnt == LAST_CELL) begin
            if (!r_plane) begin
              r_plane <= 1'b1;
              r_cnt   <= r_scroll ? LAST_ROW0 : '0;
            end else begin
              r_state <= ST_DONE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_textbuffer_ctrl.sv
// Bench for textbuffer_ctrl: behavioural textbuffer memory, array-based screen
// model for clear/scroll, CPU read scoreboard and cycle-exact command timing.
module tb_textbuffer_ctrl;

  localparam int W         = 20;
  localparam int H         = 15;
  localparam int AW        = 10;
  localparam int CELLS     = W * H;
  localparam int ATTR_BASE = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cpu_cs, cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_di;
  logic          cpu_ready;
  logic [7:0]    cpu_dout;
  logic          cmd_start, cmd;
  logic [7:0]    fill_char, fill_attr;
  logic          busy, done;
  logic          tb_cs, tb_rw;
  logic [AW-1:0] tb_addr;
  logic [7:0]    tb_di;
  logic [7:0]    tb_dout;
  logic [2:0]    dbg_state;

  textbuffer_ctrl #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
    .cpu_ready(cpu_ready), .cpu_dout(cpu_dout),
    .cmd_start(cmd_start), .cmd(cmd), .fill_char(fill_char), .fill_attr(fill_attr),
    .busy(busy), .done(done),
    .tb_cs(tb_cs), .tb_rw(tb_rw), .tb_addr(tb_addr), .tb_di(tb_di), .tb_dout(tb_dout),
    .dbg_state(dbg_state)
  );

  // Textbuffer: registered read data, one access per cycle.
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (tb_cs) begin
      if (tb_rw) mem[tb_addr] <= tb_di;
      else       tb_dout <= mem[tb_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ref_c [CELLS];
  logic [7:0] ref_a [CELLS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < CELLS; i++) begin
      chk({tag, "_char"}, mem[i], ref_c[i]);
      chk({tag, "_attr"}, mem[ATTR_BASE + i], ref_a[i]);
    end
  endtask

  // Screen-level model of the two commands.
  task automatic model_clear(input logic [7:0] fc, input logic [7:0] fa);
    for (int i = 0; i < CELLS; i++) begin
      ref_c[i] = fc;
      ref_a[i] = fa;
    end
  endtask

  task automatic model_scroll(input logic [7:0] fc, input logic [7:0] fa);
    for (int i = 0; i < W * (H - 1); i++) begin
      ref_c[i] = ref_c[i + W];
      ref_a[i] = ref_a[i + W];
    end
    for (int i = W * (H - 1); i < CELLS; i++) begin
      ref_c[i] = fc;
      ref_a[i] = fa;
    end
  endtask

  function automatic logic [AW-1:0] cell_addr(input logic plane, input int idx);
    return plane ? AW'(ATTR_BASE + idx) : AW'(idx);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cpu_access(input logic rw, input logic [AW-1:0] addr, input logic [7:0] data,
                            output int waits);
    cpu_cs = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_di = data;
    waits = 0;
    @(negedge clk);
    while (!cpu_ready && waits < 3000) begin
      @(negedge clk);
      waits++;
    end
    if (!cpu_ready) chk("cpu_grant_timeout", 0, 1);
    @(posedge clk); #1;
    cpu_cs = 1'b0; cpu_rw = 1'b0;
  endtask

  task automatic cpu_write(input logic plane, input int idx, input logic [7:0] data);
    int waits;
    cpu_access(1'b1, cell_addr(plane, idx), data, waits);
    if (plane) ref_a[idx] = data;
    else       ref_c[idx] = data;
  endtask

  task automatic cpu_read_chk(input string tag, input logic plane, input int idx);
    int waits;
    exp_q.push_back(plane ? ref_a[idx] : ref_c[idx]);
    cpu_access(1'b0, cell_addr(plane, idx), 8'h00, waits);
    chk({tag, "_wait"}, waits, 0);
    @(posedge clk); #1;
    chk(tag, cpu_dout, exp_q.pop_front());
  endtask

  task automatic preload_random();
    for (int i = 0; i < CELLS; i++) begin
      cpu_write(1'b0, i, 8'($urandom_range(0, 255)));
      cpu_write(1'b1, i, 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic preload_rows();
    for (int i = 0; i < CELLS; i++) begin
      cpu_write(1'b0, i, 8'(i / W));
      cpu_write(1'b1, i, 8'(8'h10 + i / W));
    end
  endtask

  task automatic spot_reads(input string tag);
    for (int k = 0; k < 3; k++)
      cpu_read_chk(tag, 1'($urandom_range(0, 1)), $urandom_range(0, CELLS - 1));
  endtask

  // Issues a command at cycle 0 and steps cycle by cycle, optionally injecting a
  // CPU access, a second strobe or a reset at given cycle numbers.
  task automatic run_cmd(input logic c, input logic [7:0] fc, input logic [7:0] fa,
                         input int inj_cyc, input logic inj_rw, input logic [AW-1:0] inj_addr,
                         input logic [7:0] inj_data, input int second_cyc, input int rst_cyc,
                         output int done_cyc, output int n_done, output int grant_cyc,
                         output int n_bad_ready);
    logic granted;
    granted = 1'b0; done_cyc = -1; n_done = 0; grant_cyc = -1; n_bad_ready = 0;
    cmd = c; fill_char = fc; fill_attr = fa;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      cmd_start = (cyc == 0) || (cyc == second_cyc);
      if (granted) cpu_cs = 1'b0;
      if (cyc == inj_cyc) begin
        cpu_cs = 1'b1; cpu_rw = inj_rw; cpu_addr = inj_addr; cpu_di = inj_data;
      end
      reset = (cyc == rst_cyc);
      @(negedge clk);
      if (cyc == 1) chk("busy_first_cycle", busy, 1);
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tb_cs", tb_cs, 0);
        chk("rst_state_idle", dbg_state, 0);
        break;
      end
      if (busy && cpu_ready) n_bad_ready++;
      if (cpu_cs && cpu_ready && !granted) begin
        granted = 1'b1;
        grant_cyc = cyc;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk("busy_at_done", busy, 0);
        end
      end
      if (done_cyc >= 0 && cyc > done_cyc && (inj_cyc < 0 || granted)) break;
    end
    if (done_cyc < 0 && rst_cyc < 0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_start = 1'b0; reset = 1'b0; cpu_cs = 1'b0; cpu_rw = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc, nd, gc, nb, waits, idx;
    logic c, pl;
    logic [7:0] fc, fa, dat;

    reset = 1'b1; cpu_cs = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_di = '0;
    cmd_start = 1'b0; cmd = 1'b0; fill_char = '0; fill_attr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cpu_dout", cpu_dout, 0);
    chk("reset_tb_cs", tb_cs, 0);
    chk("reset_state", dbg_state, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Pass-through write then read.
    cpu_access(1'b1, 10'd5, 8'h41, waits);
    chk("pt_write_wait", waits, 0);
    ref_c[5] = 8'h41;
    cpu_read_chk("pt_read", 1'b0, 5);

    // CLEAR with fixed fills.
    preload_random();
    run_cmd(1'b0, 8'h20, 8'h0F, -1, 1'b0, '0, '0, -1, -1, dc, nd, gc, nb);
    chk("clear_done_cycle", dc, 601);
    chk("clear_done_pulses", nd, 1);
    model_clear(8'h20, 8'h0F);
    compare_mem("clear");
    spot_reads("clear_rd");

    // SCROLL over the row-numbered pattern.
    preload_rows();
    fa = 8'($urandom_range(0, 255));
    run_cmd(1'b1, 8'h00, fa, -1, 1'b0, '0, '0, -1, -1, dc, nd, gc, nb);
    chk("scroll_done_cycle", dc, 1161);
    chk("scroll_done_pulses", nd, 1);
    model_scroll(8'h00, fa);
    compare_mem("scroll");
    chk("scroll_row0_char", mem[0], 1);
    chk("scroll_row13_attr", mem[ATTR_BASE + 13 * W], 8'h1E);

    // Random commands on random screens.
    for (int n = 0; n < 3; n++) begin
      preload_random();
      c  = 1'($urandom_range(0, 1));
      fc = 8'($urandom_range(0, 255));
      fa = 8'($urandom_range(0, 255));
      run_cmd(c, fc, fa, -1, 1'b0, '0, '0, -1, -1, dc, nd, gc, nb);
      chk("rand_done_cycle", dc, c ? 1161 : 601);
      if (c) model_scroll(fc, fa);
      else   model_clear(fc, fa);
      compare_mem("rand");
      spot_reads("rand_rd");
    end

    // CPU write held from cycle 10 of a CLEAR.
    idx = $urandom_range(0, CELLS - 1);
    pl  = 1'($urandom_range(0, 1));
    dat = 8'($urandom_range(0, 255));
    fc  = 8'($urandom_range(0, 255));
    fa  = 8'($urandom_range(0, 255));
    run_cmd(1'b0, fc, fa, 10, 1'b1, cell_addr(pl, idx), dat, -1, -1, dc, nd, gc, nb);
    chk("busy_wr_done_cycle", dc, 601);
    chk("busy_wr_grant_cycle", gc, 602);
    chk("busy_wr_no_early_ready", nb, 0);
    model_clear(fc, fa);
    if (pl) ref_a[idx] = dat;
    else    ref_c[idx] = dat;
    compare_mem("busy_wr");

    // CPU read with cmd_start in the same cycle, plus an ignored second strobe.
    preload_random();
    idx = $urandom_range(0, CELLS - 1);
    exp_q.push_back(ref_c[idx]);
    fc = 8'($urandom_range(0, 255));
    fa = 8'($urandom_range(0, 255));
    run_cmd(1'b1, fc, fa, 0, 1'b0, cell_addr(1'b0, idx), 8'h00, 50, -1, dc, nd, gc, nb);
    chk("simul_grant_cycle", gc, 0);
    chk("simul_done_cycle", dc, 1161);
    chk("simul_done_pulses", nd, 1);
    chk("simul_cpu_dout_held", cpu_dout, exp_q.pop_front());
    model_scroll(fc, fa);
    compare_mem("simul");

    // Reset at cycle 500 of a SCROLL: 250 char cells have been moved.
    preload_random();
    run_cmd(1'b1, 8'h00, 8'h00, -1, 1'b0, '0, '0, -1, 500, dc, nd, gc, nb);
    for (int i = 0; i < 250; i++) ref_c[i] = ref_c[i + W];
    dat = 8'($urandom_range(0, 255));
    cpu_access(1'b1, cell_addr(1'b1, 7), dat, waits);
    chk("post_reset_grant_wait", waits, 0);
    ref_a[7] = dat;
    compare_mem("reset_mid");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
